// File: rtl/axi_lite_loopback_pkg.sv
// Shared types and constants for the AXI4-Lite loopback: master FSM states,
// response codes and default widths.
package axi_lite_loopback_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int          DEF_ADDR_WIDTH = 4;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_NUM_TXN    = 4;
    localparam logic [31:0] DEF_START_DATA = 32'hAA00_0000;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: writes START_DATA+i to word i, reads every word back and
// flags any data mismatch or non-OKAY response.
module axi_lite_master
    import axi_lite_loopback_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    NUM_TXN    = DEF_NUM_TXN,
    parameter logic [DATA_WIDTH-1:0] START_DATA = DEF_START_DATA
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      axi_txn,
    output logic                      axi_txn_done,
    output logic                      axi_error,
    output logic [ADDR_WIDTH-1:0]     aw_addr,
    output logic [2:0]                aw_prot,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic                      w_valid,
    input  logic                      w_ready,
    input  logic [1:0]                b_resp,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [ADDR_WIDTH-1:0]     ar_addr,
    output logic [2:0]                ar_prot,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_valid,
    output logic                      r_ready
);

    localparam int                IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_TXN - 1);

    state_t           state;
    logic             txn_q, busy, err_acc;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             start, aw_hs, w_hs, b_hs, ar_hs, r_hs, r_bad;

    assign aw_prot = 3'b000;
    assign ar_prot = 3'b000;
    assign w_strb  = '1;

    assign idx_nxt = idx + 1'b1;
    assign start   = axi_txn & ~txn_q & ((state == IDLE) | (state == DONE));
    assign aw_hs   = aw_valid & aw_ready;
    assign w_hs    = w_valid & w_ready;
    assign b_hs    = b_valid & b_ready;
    assign ar_hs   = ar_valid & ar_ready;
    assign r_hs    = r_valid & r_ready;
    assign r_bad   = (r_resp != RESP_OKAY) | (r_data != START_DATA + DATA_WIDTH'(idx));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state        <= IDLE;
            txn_q        <= 1'b0;
            busy         <= 1'b0;
            err_acc      <= 1'b0;
            idx          <= '0;
            axi_txn_done <= 1'b0;
            axi_error    <= 1'b0;
            aw_addr      <= '0;
            aw_valid     <= 1'b0;
            w_data       <= '0;
            w_valid      <= 1'b0;
            b_ready      <= 1'b0;
            ar_addr      <= '0;
            ar_valid     <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            txn_q <= axi_txn;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= WRITE;
                        idx          <= '0;
                        busy         <= 1'b0;
                        err_acc      <= 1'b0;
                        axi_txn_done <= 1'b0;
                        axi_error    <= 1'b0;
                        b_ready      <= 1'b1;
                    end
                end
                WRITE: begin
                    // busy spans issue..B; the idle cycle after B spaces writes out.
                    if (!busy) begin
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        aw_addr  <= {idx, 2'b00};
                        w_data   <= START_DATA + DATA_WIDTH'(idx);
                        busy     <= 1'b1;
                    end
                    if (aw_hs) aw_valid <= 1'b0;
                    if (w_hs)  w_valid  <= 1'b0;
                    if (b_hs) begin
                        if (b_resp != RESP_OKAY) err_acc <= 1'b1;
                        busy <= 1'b0;
                        if (idx == LAST) begin
                            state   <= READ;
                            idx     <= '0;
                            b_ready <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end
                READ: begin
                    if (!busy) begin
                        ar_valid <= 1'b1;
                        ar_addr  <= {idx, 2'b00};
                        busy     <= 1'b1;
                    end
                    if (ar_hs) ar_valid <= 1'b0;
                    if (r_hs) begin
                        if (idx == LAST) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            r_ready      <= 1'b0;
                            axi_txn_done <= 1'b1;
                            axi_error    <= err_acc | r_bad;
                        end else begin
                            // Next read is issued straight off the R handshake.
                            err_acc  <= err_acc | r_bad;
                            idx      <= idx_nxt;
                            ar_valid <= 1'b1;
                            ar_addr  <= {idx_nxt, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: 2**(ADDR_WIDTH-2) word registers, one write and
// one read in flight at a time, always answering OKAY.
module axi_lite_slave_regs
    import axi_lite_loopback_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     aw_addr,
    input  logic [2:0]                aw_prot,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH/8-1:0]   w_strb,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [1:0]                b_resp,
    output logic                      b_valid,
    input  logic                      b_ready,
    input  logic [ADDR_WIDTH-1:0]     ar_addr,
    input  logic [2:0]                ar_prot,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                r_resp,
    output logic                      r_valid,
    input  logic                      r_ready
);

    localparam int NUM_REGS = 2 ** (ADDR_WIDTH - 2);
    localparam int STRB_W   = DATA_WIDTH / 8;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [ADDR_WIDTH-3:0] w_sel, r_sel;
    logic                  wr_hs, ar_hs;
    logic                  unused_bits;

    assign w_sel = aw_addr[ADDR_WIDTH-1:2];
    assign r_sel = ar_addr[ADDR_WIDTH-1:2];
    assign wr_hs = aw_valid & aw_ready & w_valid & w_ready;
    assign ar_hs = ar_valid & ar_ready;
    assign unused_bits = ^{aw_prot, ar_prot, aw_addr[1:0], ar_addr[1:0]};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            regs     <= '0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
        end else begin
            // Ready is a one-cycle pulse; the ~aw_ready term keeps it from
            // re-firing on the handshake cycle itself.
            aw_ready <= aw_valid & w_valid & ~aw_ready & ~b_valid;
            w_ready  <= aw_valid & w_valid & ~aw_ready & ~b_valid;
            if (wr_hs) begin
                for (int b = 0; b < STRB_W; b++)
                    if (w_strb[b]) regs[w_sel][8*b +: 8] <= w_data[8*b +: 8];
                b_valid <= 1'b1;
                b_resp  <= RESP_OKAY;
            end else if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end

            ar_ready <= ar_valid & ~ar_ready & ~r_valid;
            if (ar_hs) begin
                r_valid <= 1'b1;
                r_data  <= regs[r_sel];
                r_resp  <= RESP_OKAY;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_loopback_system.sv
// Loopback top: wires the five AXI4-Lite channels between the internal master
// and the register slave; only start/done/error are visible outside.
module axi_lite_loopback_system
    import axi_lite_loopback_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    NUM_TXN    = DEF_NUM_TXN,
    parameter logic [DATA_WIDTH-1:0] START_DATA = DEF_START_DATA
) (
    input  logic axi_aclk,
    input  logic axi_aresetn,
    input  logic axi_txn,
    output logic axi_txn_done,
    output logic axi_error
);

    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [2:0]              aw_prot, ar_prot;
    logic                    aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic                    ar_valid, ar_ready, r_valid, r_ready;
    logic [DATA_WIDTH-1:0]   w_data, r_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic [1:0]              b_resp, r_resp;

    axi_lite_master #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .NUM_TXN(NUM_TXN), .START_DATA(START_DATA)
    ) u_master (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .axi_txn(axi_txn),
        .axi_txn_done(axi_txn_done), .axi_error(axi_error),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

    axi_lite_slave_regs #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_slave (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

endmodule

// File: tb/tb_axi_lite_loopback_system.sv
// Directed/randomized bench for the AXI4-Lite loopback: runs, held start,
// restart, injected readback corruption and reset during the read phase.
module tb_axi_lite_loopback_system;
    import axi_lite_loopback_pkg::*;

    localparam int          ADDR_WIDTH = 4;
    localparam int          DATA_WIDTH = 32;
    localparam int          NUM_TXN    = 4;
    localparam logic [31:0] START_DATA = 32'hAA00_0000;
    localparam int          LAT_MAX    = 2 + 7 * NUM_TXN + 2;
    localparam int          RUN_CYC    = 60;

    logic axi_aclk, axi_aresetn, axi_txn, axi_txn_done, axi_error;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int ar_cnt = 0;

    // Reference model: what the register file and flags should hold.
    logic [31:0] mdl_regs [NUM_TXN];
    logic        mdl_done, mdl_err;
    logic [31:0] inj_val;

    axi_lite_loopback_system #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .NUM_TXN(NUM_TXN), .START_DATA(START_DATA)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .axi_txn(axi_txn),
        .axi_txn_done(axi_txn_done), .axi_error(axi_error)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    always @(posedge axi_aclk) begin
        if (dut.aw_valid && dut.aw_ready) aw_cnt <= aw_cnt + 1;
        if (dut.ar_valid && dut.ar_ready) ar_cnt <= ar_cnt + 1;
    end

    function automatic logic [31:0] model_word(input int i);
        return START_DATA + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_TXN; i++)
            check($sformatf("%s_reg%0d", tag, i), dut.u_slave.regs[i], mdl_regs[i]);
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_done"},     axi_txn_done, 1'b0);
        check({tag, "_error"},    axi_error,    1'b0);
        check({tag, "_aw_valid"}, dut.aw_valid, 1'b0);
        check({tag, "_w_valid"},  dut.w_valid,  1'b0);
        check({tag, "_b_valid"},  dut.b_valid,  1'b0);
        check({tag, "_ar_valid"}, dut.ar_valid, 1'b0);
        check({tag, "_r_valid"},  dut.r_valid,  1'b0);
    endtask

    // One run: axi_txn high for 'width' cycles, optional corruption of word 2's
    // read data, then judge latency, flags, registers and handshake counts.
    task automatic run(input string tag, input int width, input bit inject);
        int  aw0, ar0, lat;
        bit  got, early, forced, unforced, rel_pend;
        aw0 = aw_cnt; ar0 = ar_cnt; lat = 0;
        got = 0; early = 0; forced = 0; unforced = 0; rel_pend = 0;
        inj_val = model_word(2) ^ (32'h1 << $urandom_range(0, 31));
        check({tag, "_pre_done"}, axi_txn_done, mdl_done);
        check({tag, "_pre_error"}, axi_error, mdl_err);
        @(negedge axi_aclk); axi_txn = 1'b1;
        for (int c = 1; c <= RUN_CYC; c++) begin
            @(negedge axi_aclk);
            if (c == width) axi_txn = 1'b0;
            if (c == 1) begin
                check({tag, "_start_done_clr"}, axi_txn_done, 1'b0);
                check({tag, "_start_err_clr"},  axi_error,    1'b0);
            end
            if (rel_pend) begin release dut.r_data; rel_pend = 0; end
            if (inject && !forced && dut.ar_valid && dut.ar_ready && dut.ar_addr == 4'd8) begin
                force dut.r_data = inj_val;
                forced = 1;
            end else if (forced && !unforced && dut.r_valid && dut.r_ready) begin
                rel_pend = 1; unforced = 1;
            end
            if (!got && axi_txn_done) begin got = 1; lat = c - 1; end
            if (!got && axi_error) early = 1;
        end
        if (rel_pend) release dut.r_data;
        for (int i = 0; i < NUM_TXN; i++) mdl_regs[i] = model_word(i);
        mdl_done = 1'b1;
        mdl_err  = inject;
        check({tag, "_done_seen"}, got, 1'b1);
        check({tag, "_latency_ok"}, (lat <= LAT_MAX), 1'b1);
        check({tag, "_err_early"}, early, 1'b0);
        check({tag, "_done_held"}, axi_txn_done, mdl_done);
        check({tag, "_error"}, axi_error, mdl_err);
        check({tag, "_aw_count"}, aw_cnt - aw0, NUM_TXN);
        check({tag, "_ar_count"}, ar_cnt - ar0, NUM_TXN);
        if (inject) check({tag, "_inject_hit"}, unforced, 1'b1);
        check_regs(tag);
    endtask

    task automatic gap();
        repeat ($urandom_range(2, 8)) @(negedge axi_aclk);
    endtask

    initial begin
        bit seen;
        axi_txn     = 1'b0;
        axi_aresetn = 1'b1;
        mdl_done    = 1'b0;
        mdl_err     = 1'b0;
        for (int i = 0; i < NUM_TXN; i++) mdl_regs[i] = '0;
        #1 axi_aresetn = 1'b0;
        repeat (10) @(negedge axi_aclk);
        check_idle_bus("in_reset");
        check_regs("in_reset");
        axi_aresetn = 1'b1;
        repeat (10) @(negedge axi_aclk);
        check_idle_bus("no_pulse");
        check("no_pulse_state", 64'(dut.u_master.state), 64'(IDLE));

        run("run1", 1, 1'b0);
        gap();
        run("held20", 20, 1'b0);
        gap();
        run("restart", $urandom_range(1, 3), 1'b0);
        gap();
        run("inject", 1, 1'b1);
        repeat (10) @(negedge axi_aclk);
        check("inject_sticky", axi_error, 1'b1);
        run("after_inject", 1, 1'b0);
        gap();

        // Reset while the read phase is in progress.
        @(negedge axi_aclk); axi_txn = 1'b1;
        @(negedge axi_aclk); axi_txn = 1'b0;
        seen = 0;
        for (int c = 0; c < RUN_CYC && !seen; c++) begin
            @(negedge axi_aclk);
            if (dut.ar_valid) seen = 1;
        end
        check("mid_read_reached", seen, 1'b1);
        repeat ($urandom_range(0, 6)) @(negedge axi_aclk);
        #2 axi_aresetn = 1'b0;
        for (int i = 0; i < NUM_TXN; i++) mdl_regs[i] = '0;
        mdl_done = 1'b0;
        mdl_err  = 1'b0;
        #1;
        check_idle_bus("mid_reset");
        check_regs("mid_reset");
        check("mid_reset_state", 64'(dut.u_master.state), 64'(IDLE));
        repeat (3) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (40) @(negedge axi_aclk);
        check("post_reset_no_done", axi_txn_done, 1'b0);
        run("post_reset", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_loopback_system.md
# axi_lite_loopback_system

Self-checking AXI4-Lite loopback: an internal AXI4-Lite master writes a fixed data pattern into an internal AXI4-Lite register slave, reads it back and compares. It is the top-level simulation target for exercising AXI4-Lite handshakes. Externally it exposes only a start strobe, a completion flag and an error flag.

## Interface
- ADDR_WIDTH, 4: AXI byte-address width; the slave decodes bits [3:2].
- DATA_WIDTH, 32: AXI data width; WSTRB is DATA_WIDTH/8 bits.
- NUM_TXN, 4: number of write/read pairs per run; maximum 2**(ADDR_WIDTH-2).
- START_DATA, 32'hAA00_0000: data written to word i is START_DATA + i.
- axi_aclk  in  1  single system clock; all logic is on its rising edge.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- axi_txn  in  1  start request; a rising edge starts a run.
- axi_txn_done  out  1  level; high once a run has completed.
- axi_error  out  1  level, sticky; high if any readback mismatched or any response was not OKAY.

## Operation
- Reset (axi_aresetn=0, asynchronous) forces the master FSM to IDLE and clears all slave registers to 0. All VALID/READY signals, axi_txn_done and axi_error go to 0. Reset mid-run aborts the run with no partial completion.
- Start detection: axi_txn is registered once. A start is `axi_txn & ~axi_txn_q` in IDLE or DONE. Starts in WRITE or READ are ignored. A start clears axi_txn_done and axi_error.
- Master FSM: IDLE -> WRITE -> READ -> DONE; DONE -> WRITE on a new start.
- WRITE, for i = 0..NUM_TXN-1, strictly one transaction outstanding:
  - Drive AWADDR=4*i, AWPROT=0, WDATA=START_DATA+i, WSTRB all ones.
  - Assert AWVALID and WVALID together. Drop each one the cycle after its handshake.
  - BREADY is held high in WRITE.
  - On a B handshake, a BRESP other than OKAY sets the error. After the last B, go to READ.
- READ, for i = 0..NUM_TXN-1:
  - Assert ARVALID with ARADDR=4*i. RREADY is held high.
  - On the R handshake, compare RDATA with START_DATA+i. A mismatch or RRESP other than OKAY sets axi_error.
  - After the last R, go to DONE and assert axi_txn_done.
- Slave, 2**(ADDR_WIDTH-2) registers:
  - Asserts AWREADY and WREADY together for one cycle when AWVALID and WVALID are both high and no B is pending.
  - Writes the register with byte strobes honoured.
  - Raises BVALID the next cycle with BRESP=OKAY and holds it until BREADY.
  - Asserts ARREADY for one cycle when ARVALID is high and no R is pending.
  - Raises RVALID the next cycle with RDATA=reg[ARADDR[3:2]] and RRESP=OKAY, held until RREADY.
- Every VALID stays asserted, with stable payload, until its handshake.

## Timing
- Start-to-first-AWVALID: 2 cycles after the edge where axi_txn is first sampled high.
- Per write: AW/W accept 1 cycle after VALID, BVALID 1 cycle later, B handshake on that cycle (BREADY high). The next AWVALID follows 1 cycle after that: 4 cycles per write.
- Per read: ARREADY 1 cycle after ARVALID, RVALID next cycle, R handshake on that cycle. The next ARVALID follows 1 cycle after: 3 cycles per read.
- Completion: axi_txn_done rises the cycle after the last R handshake, no later than 2 + 7*NUM_TXN + 2 cycles after the start (32 cycles for the defaults).
- axi_txn_done and axi_error change only at start, completion and reset.

## Structure
- Package axi_lite_loopback_pkg holds:
  - the FSM state enum (IDLE, WRITE, READ, DONE);
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the default width constants.
- Sub-modules:
  - axi_lite_master, containing the FSM and checker;
  - axi_lite_slave_regs, containing the register file.
- The top level only wires the five AXI channels between the two sub-modules.

## Test plan
- Reset for 10 cycles, release, wait 10 cycles, 1-cycle axi_txn pulse:
  - axi_txn_done=1 within 32 cycles;
  - axi_error=0;
  - slave regs = AA000000, AA000001, AA000002, AA000003.
- During reset, and after release with no pulse: axi_txn_done=0, axi_error=0, all VALIDs=0.
- axi_txn held high for 20 cycles: exactly one run, 4 AW and 4 AR handshakes.
- Second pulse after DONE: axi_txn_done drops the cycle after the start is detected, then rises again; axi_error stays 0.
- Force one slave RDATA bit flipped for word 2: axi_error=1 at DONE, still 1 until the next start.
- Assert axi_aresetn low during READ: outputs go to 0 immediately, regs cleared, FSM in IDLE; the next pulse completes cleanly.
